// File: rtl/frame_sequencer_pkg.sv
// frame_pkg: shared definitions for the per-frame render sequencer.
//   - state_e              : sequencer state encoding; it is also shown on the
//                            debug 'phase' output.
//   - FRAME_TICKS_120HZ    : 50 MHz / 120 Hz frame period in clocks.
//   - SETTLE_TICKS_DEFAULT : idle clocks between the update strobe and draw start.
package frame_pkg;

    localparam int unsigned FRAME_TICKS_120HZ    = 416666;
    localparam int unsigned SETTLE_TICKS_DEFAULT = 21;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_TICK  = 3'd1,
        ST_ERASE_REQ  = 3'd2,
        ST_ERASE_WAIT = 3'd3,
        ST_UPDATE     = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_DRAW_REQ   = 3'd6,
        ST_DRAW_WAIT  = 3'd7
    } state_e;

endpackage

// File: rtl/frame_sequencer_tick_timer.sv
// tick_timer: free-running frame period timer.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   enable : level; counter runs while high and is held at 0 while low
//   tick   : registered one-cycle pulse, once every PERIOD clocks while enabled
module tick_timer #(
    parameter int unsigned PERIOD = 416666,
    parameter int unsigned CW     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_comb begin
        count_d = '0;
        tick_d  = 1'b0;
        if (enable) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame render loop controller.
// On each frame tick, one pass runs: erase -> physics update -> settle -> draw.
// Each phase uses a start/done handshake with its engine.
//   clk, reset        : system clock, asynchronous active-high reset
//   run               : level; enables the frame timer and sequencing
//   erase_done        : one-cycle completion pulse from the erase engine
//   draw_done         : one-cycle completion pulse from the draw engine
//   erase_start       : one-cycle registered request to the erase engine
//   update_en         : one-cycle registered physics/position update strobe
//   draw_start        : one-cycle registered request to the draw engine
//   phase[2:0]        : current state encoding (debug LEDs)
//   frame_count[15:0] : completed frames, wraps
//   overrun           : sticky; a frame tick arrived while one was still pending
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_TICKS  = FRAME_TICKS_120HZ,
    parameter int unsigned SETTLE_TICKS = SETTLE_TICKS_DEFAULT,
    parameter int unsigned CW           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        erase_done,
    input  logic        draw_done,
    output logic        erase_start,
    output logic        update_en,
    output logic        draw_start,
    output logic [2:0]  phase,
    output logic [15:0] frame_count,
    output logic        overrun
);

    localparam int unsigned   SW          = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);

    logic          tick;
    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   fc_q, fc_d;
    logic          es_q, ue_q, ds_q;

    tick_timer #(
        .PERIOD (FRAME_TICKS),
        .CW     (CW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (run),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        fc_d      = fc_q;

        // A tick is remembered until WAIT_TICK consumes it.
        // A second tick arriving before then is dropped and flagged.
        if (tick) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (!run) begin
                    state_d   = ST_IDLE;
                    pending_d = 1'b0;
                end else if (pending_q || tick) begin
                    state_d   = ST_ERASE_REQ;
                    pending_d = 1'b0;
                end
            end
            ST_ERASE_REQ: state_d = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (erase_done) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_DRAW_REQ;
                else                         settle_d = settle_q + SW'(1);
            end
            ST_DRAW_REQ: state_d = ST_DRAW_WAIT;
            ST_DRAW_WAIT: begin
                if (draw_done) begin
                    state_d = ST_WAIT_TICK;
                    fc_d    = fc_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            fc_q      <= '0;
            es_q      <= 1'b0;
            ue_q      <= 1'b0;
            ds_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            fc_q      <= fc_d;
            // Strobes are registered from the next state.
            // They line up with the state they belong to, with no input-to-output path.
            es_q      <= (state_d == ST_ERASE_REQ);
            ue_q      <= (state_d == ST_UPDATE);
            ds_q      <= (state_d == ST_DRAW_REQ);
        end
    end

    assign erase_start = es_q;
    assign update_en   = ue_q;
    assign draw_start  = ds_q;
    assign phase       = state_q;
    assign frame_count = fc_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_TICKS=10 and SETTLE_TICKS=3.
// Cycle n is the interval after the n-th rising edge following reset release.
// At that release, run is driven high.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        erase_done, draw_done;
    logic        erase_start, update_en, draw_start, overrun;
    logic [2:0]  phase;
    logic [15:0] frame_count;

    logic eng_ed = 1'b0, eng_dd = 1'b0;
    logic spur_ed = 1'b0, spur_dd = 1'b0;
    logic eng_on = 1'b0;
    int   erase_lat = 2, draw_lat = 2;
    int   ecnt = 0, dcnt = 0;
    int   cyc = 0, base = 0;
    int   checks = 0, errors = 0;

    assign erase_done = eng_ed | spur_ed;
    assign draw_done  = eng_dd | spur_dd;

    frame_sequencer #(
        .FRAME_TICKS  (10),
        .SETTLE_TICKS (3),
        .CW           (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .erase_done  (erase_done),
        .draw_done   (draw_done),
        .erase_start (erase_start),
        .update_en   (update_en),
        .draw_start  (draw_start),
        .phase       (phase),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: a done pulse is sampled (lat+1) edges after the start request is seen.
    always @(negedge clk) begin
        if (reset) begin
            ecnt   <= 0;
            dcnt   <= 0;
            eng_ed <= 1'b0;
            eng_dd <= 1'b0;
        end else begin
            eng_ed <= eng_on && (ecnt == 1);
            eng_dd <= eng_on && (dcnt == 1);
            ecnt   <= erase_start ? erase_lat : ((ecnt > 0) ? ecnt - 1 : 0);
            dcnt   <= draw_start  ? draw_lat  : ((dcnt > 0) ? dcnt - 1 : 0);
        end
    end

    typedef struct {
        logic        run, ed, dd;
        logic        es, ue, ds, ov;
        logic [2:0]  ph;
        logic [15:0] fc;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(input logic ed, input logic dd, input logic es,
                                input logic ue, input logic ds,
                                input logic [2:0] ph, input logic [15:0] fc);
        vec_t v;
        v.run = 1'b1; v.ed = ed; v.dd = dd;
        v.es = es; v.ue = ue; v.ds = ds; v.ov = 1'b0;
        v.ph = ph; v.fc = fc;
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return {9'b0, erase_start, update_en, draw_start, overrun, phase, frame_count};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc - base);
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc - base < c) @(negedge clk);
    endtask

    task automatic start_run(input int el, input int dl, input logic engines);
        @(negedge clk);
        reset = 1'b1; run = 1'b0; spur_ed = 1'b0; spur_dd = 1'b0;
        eng_on = engines; erase_lat = el; draw_lat = dl;
        @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0; run = 1'b1; base = cyc;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        vt[0] = mk(0, 0, 0, 0, 0, 3'd0, 16'd0);
        for (int i = 1; i <= 10; i++) vt[i] = mk(0, 0, 0, 0, 0, 3'd1, 16'd0);
        vt[11] = mk(0, 0, 1, 0, 0, 3'd2, 16'd0);
        vt[12] = mk(0, 0, 0, 0, 0, 3'd3, 16'd0);
        vt[13] = mk(1, 0, 0, 0, 0, 3'd3, 16'd0);
        vt[14] = mk(0, 0, 0, 1, 0, 3'd4, 16'd0);
        for (int i = 15; i <= 17; i++) vt[i] = mk(0, 0, 0, 0, 0, 3'd5, 16'd0);
        vt[18] = mk(0, 0, 0, 0, 1, 3'd6, 16'd0);
        vt[19] = mk(0, 0, 0, 0, 0, 3'd7, 16'd0);
        vt[20] = mk(0, 1, 0, 0, 0, 3'd7, 16'd0);
        vt[21] = mk(0, 0, 0, 0, 0, 3'd1, 16'd1);
        vt[22] = mk(0, 0, 1, 0, 0, 3'd2, 16'd1);
        vt[23] = mk(0, 0, 0, 0, 0, 3'd3, 16'd1);

        // First frame: done pulses come from the table, 2 cycles after each start.
        // The tick at frame end is latched.
        start_run(2, 2, 1'b0);
        for (int i = 0; i < 24; i++) begin
            to_cycle(i);
            chk($sformatf("vec%0d", i), outs(),
                {9'b0, vt[i].es, vt[i].ue, vt[i].ds, vt[i].ov, vt[i].ph, vt[i].fc});
            run = vt[i].run; spur_ed = vt[i].ed; spur_dd = vt[i].dd;
        end
        spur_ed = 1'b0; spur_dd = 1'b0;

        // Five back-to-back frames with prompt engines.
        start_run(1, 1, 1'b1);
        for (int f = 0; f < 5; f++) begin
            int k;
            k = 11 + 10 * f;
            to_cycle(k - 1); chk($sformatf("b2b_pre_es%0d", f), erase_start, 1'b0);
            to_cycle(k);     chk($sformatf("b2b_es%0d", f), erase_start, 1'b1);
            to_cycle(k + 2); chk($sformatf("b2b_ue%0d", f), update_en, 1'b1);
            to_cycle(k + 6); chk($sformatf("b2b_ds%0d", f), draw_start, 1'b1);
        end
        to_cycle(60);
        chk("b2b_fc", frame_count, 16'd5);
        chk("b2b_ov", overrun, 1'b0);
        chk("b2b_phase", phase, 3'd1);

        // erase_done is withheld: the first extra tick is latched, the second sets overrun.
        start_run(25, 1, 1'b1);
        to_cycle(30); chk("ovr_before", overrun, 1'b0); chk("ovr_wait30", phase, 3'd3);
        to_cycle(31); chk("ovr_set", overrun, 1'b1);
        to_cycle(36); chk("ovr_wait36", phase, 3'd3); erase_lat = 1;
        to_cycle(37); chk("ovr_ue", update_en, 1'b1);
        to_cycle(41); chk("ovr_ds", draw_start, 1'b1);
        to_cycle(43); chk("ovr_fc", frame_count, 16'd1); chk("ovr_ph43", phase, 3'd1);
        to_cycle(44); chk("ovr_resume_es", erase_start, 1'b1); chk("ovr_sticky", overrun, 1'b1);

        // run drops during ERASE_WAIT: the frame completes, then the sequencer goes idle.
        start_run(2, 2, 1'b1);
        to_cycle(12); chk("rd_ph12", phase, 3'd3); run = 1'b0;
        to_cycle(21); chk("rd_ph21", phase, 3'd1); chk("rd_fc", frame_count, 16'd1);
        to_cycle(22); chk("rd_idle", phase, 3'd0);
        n = 0;
        for (int c = 22; c <= 52; c++) begin
            to_cycle(c);
            if (erase_start) n++;
        end
        chk("rd_no_erase", n, 0);
        chk("rd_idle_end", phase, 3'd0);

        // Asynchronous reset between edges while in SETTLE of the second frame.
        start_run(1, 1, 1'b1);
        to_cycle(25); chk("ar_pre_ph", phase, 3'd5); chk("ar_pre_fc", frame_count, 16'd1);
        #2 reset = 1'b1;
        #1 chk("ar_outs", outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0; run = 1'b0;

        // A spurious draw_done in WAIT_TICK is ignored.
        // A spurious erase_done there is not latched.
        start_run(1, 1, 1'b1);
        to_cycle(19); chk("sp_ph19", phase, 3'd1); chk("sp_fc19", frame_count, 16'd1);
        spur_dd = 1'b1; spur_ed = 1'b1; erase_lat = 3;
        to_cycle(20); spur_dd = 1'b0; spur_ed = 1'b0;
        chk("sp_ph20", phase, 3'd1); chk("sp_fc20", frame_count, 16'd1);
        to_cycle(21); chk("sp_es", erase_start, 1'b1);
        to_cycle(23); chk("sp_wait23", phase, 3'd3);
        to_cycle(24); chk("sp_wait24", phase, 3'd3);
        to_cycle(25); chk("sp_ue", update_en, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
